// File: rtl/fifo_burst_reader.sv
// Read-side burst master: pops BURST_LEN words from a FIFO with 1-cycle read latency and
// presents them on a valid/ready stream through a 2-entry skid buffer, marking the last word.
module fifo_burst_reader #(
  parameter int DBits     = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [DBits-1:0] fifo_rd_data,
  input  logic             start,
  output logic             busy,
  output logic [DBits-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done,
  output logic [CNT_W-1:0] words_sent
);

  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [DBits-1:0] buf0, buf1;
  logic [1:0]       occ;
  logic             inflight;
  logic [BW-1:0]    issued, sent;
  logic             xfer;
  logic [2:0]       level;

  // Stream handshake: a word moves on every edge where out_valid and out_ready are both high;
  // once out_valid rises, out_data/out_last hold until that transfer happens.
  assign out_valid = (occ != 2'd0);
  assign out_data  = buf0;
  assign out_last  = out_valid && (sent == BW'(BURST_LEN - 1));
  assign xfer      = out_valid && out_ready;

  // Slots committed after this edge; the word being accepted now frees its slot.
  assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};

  assign fifo_rd_en = (state == RUN) && !fifo_empty &&
                      (issued < BW'(BURST_LEN)) && (level < 3'd2);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (xfer && out_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state      <= IDLE;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      issued     <= '0;
      sent       <= '0;
      words_sent <= '0;
      buf0       <= '0;
      buf1       <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
      if (xfer) words_sent <= words_sent + 1'b1;

      if (state == IDLE && start) begin
        issued <= '0;
        sent   <= '0;
      end else begin
        if (fifo_rd_en) issued <= issued + 1'b1;
        if (xfer)       sent   <= sent + 1'b1;
      end

      // Skid buffer: buf0 is the head, buf1 holds a second word while the head is stalled.
      case ({inflight, xfer})
        2'b10: begin
          if (occ == 2'd0) buf0 <= fifo_rd_data;
          else             buf1 <= fifo_rd_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= fifo_rd_data;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FIFO, an expected-word queue and
// per-cycle stream-rule checks.
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          start = 1'b0;
  logic          busy;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          done;
  logic [CW-1:0] words_sent;

  fifo_burst_reader #(.DBits(DW), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .clk(clk), .areset(areset), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .start(start), .busy(busy), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .done(done),
    .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: pop is honoured when rd_en & !empty, data appears the next cycle.
  logic [DW-1:0] fq[$];
  logic          wr_en = 1'b0;
  logic          fifo_clr = 1'b0;
  logic [DW-1:0] wr_data = '0;

  always @(posedge clk) begin
    if (fifo_clr) begin
      fq.delete();
    end else begin
      if (fifo_rd_en && !fifo_empty && fq.size() > 0) fifo_rd_data <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
    end
    fifo_empty <= fifo_clr ? 1'b1 : (fq.size() == 0);
  end

  logic [DW:0]   exp_q[$];
  logic [1:0]    pos = 2'd0;
  logic [CW-1:0] exp_ws = '0;
  int            checks = 0;
  int            passed = 0;
  int            cyc = 0;
  int            pops = 0, xfers = 0, burst_pops = 0, burst_xfers = 0;
  int            first_x = 0, last_x = 0, start_cyc = 0;
  logic          prev_stall = 1'b0, prev_last_xfer = 1'b0, saw_done = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Sample away from the active edge and apply the per-cycle stream rules.
  task automatic sample();
    logic          xf;
    logic [DW:0]   e;
    @(negedge clk);
    xf = out_valid && out_ready;
    chk("words_sent", 32'(words_sent), 32'(exp_ws));
    chk("done_pulse", 32'(done), 32'(prev_last_xfer));
    if (done) saw_done = 1'b1;
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(prev_data));
      chk("stall_last", 32'(out_last), 32'(prev_last));
    end
    if (xf) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 'x;
      chk("word", 32'({out_last, out_data}), 32'(e));
      if (burst_xfers == 0) first_x = cyc;
      last_x = cyc;
      xfers++;
      burst_xfers++;
      exp_ws = exp_ws + 1'b1;
    end
    if (fifo_rd_en && !fifo_empty) begin
      pops++;
      burst_pops++;
    end
    chk("buffered_le2", 32'((pops - xfers) <= 2), 32'd1);
    prev_stall     = out_valid && !out_ready;
    prev_data      = out_data;
    prev_last      = out_last;
    prev_last_xfer = xf && out_last;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic fifo_write(input logic [DW-1:0] d);
    exp_q.push_back({pos == 2'd3, d});
    pos = pos + 2'd1;
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_reset(input int n);
    areset = 1'b1;
    fifo_clr = 1'b1;
    repeat (n) advance();
    areset = 1'b0;
    fifo_clr = 1'b0;
    exp_q.delete();
    pos = 2'd0;
    exp_ws = '0;
    prev_stall = 1'b0;
    prev_last_xfer = 1'b0;
    pops = 0;
    xfers = 0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
  endtask

  task automatic begin_burst();
    burst_pops = 0;
    burst_xfers = 0;
    saw_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !saw_done; i++) tick();
    chk({tag, "_done_seen"}, 32'(saw_done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset(2);
    sample();
    chk_idle_outputs("rst");
    advance();

    // Reset mid-burst with the buffer full, start held high through reset
    for (int i = 0; i < 4; i++) fifo_write(8'h01 + 8'(i));
    out_ready = 1'b0;
    begin_burst();
    repeat (6) tick();
    chk("t1_pops", 32'(burst_pops), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    start = 1'b1;
    do_reset(2);
    start = 1'b0;
    sample();
    chk_idle_outputs("t1");
    advance();
    sample();
    chk("t1_idle_busy", 32'(busy), 32'd0);
    advance();

    // Streaming with latency checks
    for (int i = 0; i < 4; i++) fifo_write(8'h11 * 8'(i + 1));
    out_ready = 1'b1;
    begin_burst();
    start_cyc = cyc;
    sample();
    chk("lat_rd_en", 32'(fifo_rd_en), 32'd1);
    chk("lat_busy", 32'(busy), 32'd1);
    advance();
    sample();
    chk("lat_c2_valid", 32'(out_valid), 32'd0);
    advance();
    sample();
    chk("lat_c3_valid", 32'(out_valid), 32'd1);
    advance();
    wait_done("t2", 20);
    chk("t2_pops", 32'(burst_pops), 32'd4);
    chk("t2_xfers", 32'(burst_xfers), 32'd4);
    chk("t2_first_cycle", 32'(first_x - start_cyc), 32'd2);
    chk("t2_consecutive", 32'(last_x - first_x), 32'd3);
    tick();

    // Backpressure: ready pattern 1,0,0,1
    for (int i = 0; i < 4; i++) fifo_write(8'h31 + 8'(i));
    begin_burst();
    for (int i = 0; i < 60 && !saw_done; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    chk("t3_done_seen", 32'(saw_done), 32'd1);
    chk("t3_xfers", 32'(burst_xfers), 32'd4);
    chk("t3_pops", 32'(burst_pops), 32'd4);
    out_ready = 1'b1;
    tick();

    // Empty mid-burst stall
    fifo_write(8'hA1);
    begin_burst();
    repeat (10) tick();
    sample();
    chk("t4_stall_xfers", 32'(burst_xfers), 32'd1);
    chk("t4_stall_busy", 32'(busy), 32'd1);
    chk("t4_stall_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t4_stall_valid", 32'(out_valid), 32'd0);
    advance();
    fifo_write(8'hA2);
    fifo_write(8'hA3);
    fifo_write(8'hA4);
    wait_done("t4", 20);
    chk("t4_xfers", 32'(burst_xfers), 32'd4);
    tick();

    // Ignored start during a burst; surplus words stay in the FIFO
    for (int i = 0; i < 6; i++) fifo_write(8'h51 + 8'(i));
    begin_burst();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5a", 30);
    chk("t5a_pops", 32'(burst_pops), 32'd4);
    chk("t5a_fifo_left", 32'(fq.size()), 32'd2);
    repeat (5) tick();
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_idle_pops", 32'(burst_pops), 32'd4);
    fifo_write(8'h57);
    fifo_write(8'h58);
    begin_burst();
    wait_done("t5b", 20);
    chk("t5b_pops", 32'(burst_pops), 32'd4);
    chk("t5b_fifo_left", 32'(fq.size()), 32'd0);
    tick();

    // Wrap: 20 words sent since reset with a 4-bit counter
    sample();
    chk("t6_wrap", 32'(words_sent), 32'd4);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    advance();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
